// File: rtl/clock_time_ctrl_if.sv
// clock_time_ctrl_if
// Groups the user controls and the timekeeping outputs of clock_time_ctrl.
//   master : drives the buttons/switch, observes the time, alarm, mode and ring
//   slave  : the clock_time_ctrl side
// Signals:
//   btn_mode, btn_inc, alarm_en : button levels / alarm arm switch
//   sec, min, alarm_min         : 0..59 each
//   mode                        : 00 RUN, 01 SET_MIN, 10 SET_SEC, 11 SET_ALM
//   ring                        : alarm sounding
interface clock_time_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       alarm_en;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] alarm_min;
  logic [1:0] mode;
  logic       ring;

  modport master (
    output btn_mode, btn_inc, alarm_en,
    input  sec, min, alarm_min, mode, ring
  );

  modport slave (
    input  btn_mode, btn_inc, alarm_en,
    output sec, min, alarm_min, mode, ring
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl
// MM:SS timekeeping, mode sequencing and alarm/ring control in the 1 Hz domain.
// Ports:
//   clk_1Hz : tick clock, rising edge
//   rst     : asynchronous, active-high reset
//   bus     : clock_time_ctrl_if.slave (buttons, alarm switch, time/alarm/mode/ring)
// Parameters:
//   RING_LEN   : ticks ring stays high per alarm event (1..63)
//   SNOOZE_LEN : ticks from snooze to re-ring (1..63), CLOCK_SNOOZE_EN builds only
// Build option:
//   CLOCK_SNOOZE_EN : btn_inc while ringing snoozes instead of cancelling
//
// state   | meaning
// RUN     | time counting, btn_inc ignored
// SET_MIN | time frozen, btn_inc advances minutes
// SET_SEC | time frozen, btn_inc advances seconds (no carry)
// SET_ALM | time counting, btn_inc advances alarm minute
module clock_time_ctrl #(
  parameter int RING_LEN   = 30,
  parameter int SNOOZE_LEN = 60
) (
  input logic              clk_1Hz,
  input logic              rst,
  clock_time_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10,
    SET_ALM = 2'b11
  } mode_t;

  localparam logic [5:0] RING_V = 6'(RING_LEN);

  mode_t      state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [5:0] alm_q, alm_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic       ring_q;
  logic       btn_mode_q;
  logic       armed_q;

  logic       mode_rise;
  logic       counting;
  logic       inc_ok;
  logic       cancel;
  logic       hit;

`ifdef CLOCK_SNOOZE_EN
  localparam logic [5:0] SNOOZE_V = 6'(SNOOZE_LEN);
  logic [5:0] snz_q, snz_d;
  logic       snooze_req;
`else
  logic       unused_snooze_len;
  assign unused_snooze_len = (SNOOZE_LEN != 0);
`endif

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    min_d      = min_q;
    alm_d      = alm_q;
    ring_cnt_d = ring_cnt_q;

    mode_rise = bus.btn_mode & ~btn_mode_q;
    counting  = (state_q == RUN) || (state_q == SET_ALM);
    // while ringing, buttons act on the alarm only, never on a field
    inc_ok    = bus.btn_inc & ~mode_rise & ~ring_q;

    if (mode_rise && !ring_q) begin
      case (state_q)
        RUN:     state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        SET_SEC: state_d = SET_ALM;
        default: state_d = RUN;
      endcase
    end

    if (counting) begin
      sec_d = inc60(sec_q);
      if (sec_q == 6'd59) min_d = inc60(min_q);
    end

    case (state_q)
      SET_MIN: if (inc_ok) min_d = inc60(min_q);
      SET_SEC: if (inc_ok) sec_d = inc60(sec_q);
      SET_ALM: if (inc_ok) alm_d = inc60(alm_q);
      default: ;
    endcase

`ifdef CLOCK_SNOOZE_EN
    cancel     = ring_q & (mode_rise | ~bus.alarm_en);
    snooze_req = ring_q & bus.btn_inc & ~cancel;
`else
    cancel     = ring_q & (mode_rise | ~bus.alarm_en | bus.btn_inc);
`endif

    // Hit is gated on the mode we land in so that ring can only ever be
    // seen with RUN or SET_ALM; a button acting on the current ring wins
    // over a coincident new hit.
    hit = counting & bus.alarm_en & (sec_d == 6'd0) & (min_d == alm_q) &
          ((state_d == RUN) || (state_d == SET_ALM)) &
          ~(ring_q & (mode_rise | bus.btn_inc));

    if (ring_q) ring_cnt_d = cancel ? 6'd0 : ring_cnt_q - 6'd1;

`ifdef CLOCK_SNOOZE_EN
    snz_d = snz_q;
    if (snz_q != 6'd0) begin
      if (mode_rise || !bus.alarm_en) begin
        snz_d = 6'd0;
      end else begin
        snz_d = snz_q - 6'd1;
        if (snz_q == 6'd1) ring_cnt_d = RING_V;
      end
    end
    if (snooze_req) begin
      snz_d      = SNOOZE_V;
      ring_cnt_d = 6'd0;
    end
    if (hit) snz_d = 6'd0;
`endif

    if (hit) ring_cnt_d = RING_V;
  end

  // First edge after reset release only arms the block; counting starts on
  // the second edge.
  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      alm_q      <= 6'd0;
      ring_cnt_q <= 6'd0;
      ring_q     <= 1'b0;
      btn_mode_q <= 1'b0;
      armed_q    <= 1'b0;
`ifdef CLOCK_SNOOZE_EN
      snz_q      <= 6'd0;
`endif
    end else if (!armed_q) begin
      armed_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      alm_q      <= alm_d;
      ring_cnt_q <= ring_cnt_d;
      ring_q     <= (ring_cnt_d != 6'd0);
      btn_mode_q <= bus.btn_mode;
`ifdef CLOCK_SNOOZE_EN
      snz_q      <= snz_d;
`endif
    end
  end

  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.alarm_min = alm_q;
  assign bus.mode      = state_q;
  assign bus.ring      = ring_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl
// Randomized and directed stimulus for clock_time_ctrl, checked every tick
// against a seconds-of-hour reference model. Honours CLOCK_SNOOZE_EN.
module tb_clock_time_ctrl;
  localparam int RING_LEN   = 30;
  localparam int SNOOZE_LEN = 60;

  logic clk_1Hz = 1'b0;
  logic rst;
  logic bm, bi, ae;
  int   checks = 0;
  int   failures = 0;

  clock_time_ctrl_if bus ();
  assign bus.btn_mode = bm;
  assign bus.btn_inc  = bi;
  assign bus.alarm_en = ae;

  clock_time_ctrl #(.RING_LEN(RING_LEN), .SNOOZE_LEN(SNOOZE_LEN)) dut (
    .clk_1Hz(clk_1Hz),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // reference state: time as seconds into the hour, remaining ring/snooze ticks
  int m_t, m_am, m_md, m_ring, m_snz;
  bit m_bq, m_armed;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_am = 0; m_md = 0; m_ring = 0; m_snz = 0;
    m_bq = 0; m_armed = 0;
  endtask

  task automatic model_step();
    int  nt, nam, nmd, nring, nsnz;
    bit  rise, ringing, counting, inc_ok, hit, cancel, snz_req;
    if (!m_armed) begin
      m_armed = 1;
      return;
    end
    rise     = bm && !m_bq;
    m_bq     = bm;
    ringing  = (m_ring > 0);
    counting = (m_md == 0) || (m_md == 3);
    inc_ok   = bi && !rise && !ringing;
    nt = m_t; nam = m_am; nmd = m_md;
    if (rise && !ringing) nmd = (m_md + 1) % 4;
    if (counting) nt = (m_t + 1) % 3600;
    if (inc_ok) begin
      if (m_md == 1) nt  = (((m_t / 60) + 1) % 60) * 60 + m_t % 60;
      if (m_md == 2) nt  = (m_t / 60) * 60 + ((m_t % 60) + 1) % 60;
      if (m_md == 3) nam = (m_am + 1) % 60;
    end
    hit = counting && ae && (nt == m_am * 60) && (nmd == 0 || nmd == 3) &&
          !(ringing && (rise || bi));
`ifdef CLOCK_SNOOZE_EN
    cancel  = ringing && (rise || !ae);
    snz_req = ringing && bi && !cancel;
`else
    cancel  = ringing && (rise || !ae || bi);
    snz_req = 0;
`endif
    nring = m_ring;
    nsnz  = m_snz;
    if (ringing) nring = (cancel || snz_req) ? 0 : m_ring - 1;
    if (m_snz > 0) begin
      if (rise || !ae) nsnz = 0;
      else begin
        nsnz = m_snz - 1;
        if (nsnz == 0) nring = RING_LEN;
      end
    end
    if (snz_req) nsnz = SNOOZE_LEN;
    if (hit) begin
      nring = RING_LEN;
      nsnz  = 0;
    end
    m_t = nt; m_am = nam; m_md = nmd; m_ring = nring; m_snz = nsnz;
  endtask

  task automatic compare_all();
    check("sec",       bus.sec,       m_t % 60);
    check("min",       bus.min,       m_t / 60);
    check("alarm_min", bus.alarm_min, m_am);
    check("mode",      bus.mode,      m_md);
    check("ring",      bus.ring,      (m_ring > 0) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk_1Hz);
    model_step();
    @(negedge clk_1Hz);
    compare_all();
  endtask

  // called at a negedge; asserts rst mid-cycle and checks it acts at once
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_sec",  bus.sec,       0);
    check("rst_min",  bus.min,       0);
    check("rst_alm",  bus.alarm_min, 0);
    check("rst_mode", bus.mode,      0);
    check("rst_ring", bus.ring,      0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  task automatic press_mode();
    bm = 1'b1;
    tick();
    bm = 1'b0;
    tick();
  endtask

  // arms the alarm for two minutes ahead and waits until it rings
  task automatic ring_soon();
    ae = 1'b1;
    for (int i = 0; i < 8 && m_md != 3; i++) press_mode();
    bi = 1'b1;
    for (int i = 0; i < 100 && m_am != ((m_t / 60) + 2) % 60; i++) tick();
    bi = 1'b0;
    press_mode();
    for (int i = 0; i < 300 && m_ring == 0; i++) tick();
    check("ring_soon", bus.ring, 1);
  endtask

  initial begin
    int n, md_before;
    bm = 0; bi = 0; ae = 0;
    rst = 1'b1;
    model_reset();
    #2;
    check("por_sec",  bus.sec,       0);
    check("por_min",  bus.min,       0);
    check("por_alm",  bus.alarm_min, 0);
    check("por_mode", bus.mode,      0);
    check("por_ring", bus.ring,      0);
    @(negedge clk_1Hz);
    rst = 1'b0;

    // release edge is idle, then 125 counting ticks
    tick();
    check("idle_edge_sec", bus.sec, 0);
    repeat (125) tick();
    check("t125_min", bus.min, 2);
    check("t125_sec", bus.sec, 5);
    repeat (3475) tick();
    check("wrap_min", bus.min, 0);
    check("wrap_sec", bus.sec, 0);

    // SET_MIN / SET_SEC
    press_mode();
    check("setmin_mode", bus.mode, 1);
    bi = 1'b1;
    repeat (3) tick();
    bi = 1'b0;
    check("setmin_min", bus.min, 3);
    check("setmin_sec_frozen", bus.sec, 1);
    press_mode();
    check("setsec_mode", bus.mode, 2);
    bi = 1'b1;
    for (int i = 0; i < 60 && (m_t % 60) != 59; i++) tick();
    tick();
    bi = 1'b0;
    check("setsec_wrap_sec", bus.sec, 0);
    check("setsec_no_carry", bus.min, 3);

    // alarm at 01:00 set through SET_ALM, full-length ring
    do_reset();
    tick();
    repeat (3) press_mode();
    bi = 1'b1;
    tick();
    bi = 1'b0;
    press_mode();
    check("alm_set", bus.alarm_min, 1);
    ae = 1'b1;
    for (int i = 0; i < 100 && m_ring == 0; i++) tick();
    check("hit_ring", bus.ring, 1);
    check("hit_min", bus.min, 1);
    check("hit_sec", bus.sec, 0);
    n = 0;
    while (bus.ring && n < 80) begin
      tick();
      n++;
    end
    check("ring_len", n, RING_LEN);

    // cancel by mode press: ring drops, mode holds
    ring_soon();
    tick();
    md_before = m_md;
    bm = 1'b1;
    tick();
    bm = 1'b0;
    check("cancel_mode_ring", bus.ring, 0);
    check("cancel_mode_hold", bus.mode, md_before);
    tick();

    // cancel by disarm
    ring_soon();
    ae = 1'b0;
    tick();
    check("cancel_en_ring", bus.ring, 0);
    ae = 1'b1;
    tick();

    // btn_inc while ringing: snooze or cancel depending on build
    ring_soon();
    bi = 1'b1;
    tick();
    bi = 1'b0;
    check("inc_ring_drop", bus.ring, 0);
    n = 0;
    while (!bus.ring && n < 100) begin
      tick();
      n++;
    end
`ifdef CLOCK_SNOOZE_EN
    check("snooze_delay", n, SNOOZE_LEN);
`else
    check("no_rering", n, 100);
`endif

    // async reset mid-ring, no re-trigger afterwards
    ring_soon();
    tick();
    do_reset();
    repeat (4) tick();
    check("post_rst_ring", bus.ring, 0);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      bm = ($urandom_range(0, 7) == 0);
      bi = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) ae = ~ae;
      if ($urandom_range(0, 599) == 0) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Timekeeping and user-control sequencer for the MM:SS digital clock. It owns the minute/second counters that feed the display multiplexer and runs a four-state mode FSM: run, set minutes, set seconds, set alarm. It also runs an alarm comparator with a fixed-length ring and an optional snooze. It runs entirely in the 1 Hz domain, between the 1 Hz clock divider and the display multiplexer.

## Interface
- RING_LEN, 30, ticks `ring` stays high per alarm event; legal range 1..63.
- SNOOZE_LEN, 60, ticks from snooze to re-ring; legal range 1..63; used only with `SNOOZE_EN`.

- clk_1Hz  in  1  tick clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- btn_mode  in  1  mode button level; debounced and synchronized upstream.
- btn_inc  in  1  increment button level; debounced and synchronized upstream.
- alarm_en  in  1  alarm arm switch (level).
- sec  out  6  seconds, 0..59.
- min  out  6  minutes, 0..59.
- alarm_min  out  6  alarm minute, 0..59; alarm second is fixed at 0.
- mode  out  2  encoding: 00 RUN, 01 SET_MIN, 10 SET_SEC, 11 SET_ALM.
- ring  out  1  alarm sounding.

## Operation
- All outputs are registered.
- Reset values: sec=0, min=0, alarm_min=0, mode=RUN, ring=0. The internal ring counter, snooze counter and `btn_mode` history register all reset to 0.
- Mode edge detection: mode_rise = btn_mode & ~btn_mode_q.
  - `btn_inc` is level-sensitive. Holding it auto-repeats at one increment per tick.
- FSM transitions: RUN→SET_MIN→SET_SEC→SET_ALM→RUN, one step per mode_rise.
  - mode_rise has priority over `btn_inc` in the same tick; the increment is dropped.
- Counting is active in RUN and SET_ALM and frozen in SET_MIN and SET_SEC.
  - sec advances by 1 per tick, wrapping 59→0 with a carry into min.
  - min wraps 59→0 without carry.
- SET_MIN: btn_inc increments min modulo 60. sec is held.
- SET_SEC: btn_inc increments sec modulo 60, with no carry into min.
- SET_ALM: btn_inc increments alarm_min modulo 60. Time keeps counting.
- Alarm hit:
  - Condition: counting active, alarm_en=1, and the next-state time equals alarm_min:00.
  - Response: ring rises on that same edge and the ring counter loads RING_LEN.
  - No hit on reset or on manual set, because the condition is transition-based.
  - The 59:59→00:00 wrap hits when alarm_min=0.
- While ring=1:
  - The ring counter decrements each tick. ring drops on the edge where the counter reaches 0, so ring is high for exactly RING_LEN ticks.
  - mode_rise cancels: ring drops on the next edge and mode does NOT advance.
  - alarm_en=0 cancels on the next edge.
  - btn_inc behaviour depends on `SNOOZE_EN` (see Configuration). It never increments a field while ringing.
- A new hit while already ringing reloads RING_LEN.
- The only valid ring/mode combinations are ring=1 with mode=RUN or mode=SET_ALM.

## Timing
- Time, mode and ring each update at the edge following the input sample: one-tick latency.
- Button press-to-response latency is at most 1 tick.
  - A mode press must span one sampled edge to be seen.
  - A press shorter than 1 s may be missed. This is acceptable because presses are human-scale.
- rst asserted at any time, including mid-ring, mid-snooze or mid-set, forces all reset values immediately, independent of the clock.
- Release of rst is synchronous to the next clk_1Hz edge; the first count happens at the second edge.

## Configuration
- `CLOCK_SNOOZE_EN` defined:
  - btn_inc while ring=1 drops ring next edge and loads the snooze counter with SNOOZE_LEN.
  - The snooze counter decrements each tick. On the edge it reaches 0, ring re-asserts for RING_LEN ticks, provided alarm_en=1.
  - mode_rise or alarm_en=0 during snooze clears it; no re-ring follows.
  - Snooze count is unlimited.
  - A new alarm hit during snooze clears the snooze and rings normally.
- `CLOCK_SNOOZE_EN` undefined:
  - btn_inc while ring=1 cancels exactly as mode_rise does.
  - No snooze counter is synthesized, and SNOOZE_LEN is ignored.

## Test plan
- Reset released, 125 ticks in RUN → min=2, sec=5; after a further 3475 ticks, a total of 60:00 (3600 ticks) wraps to min=0, sec=0.
- mode_rise ×1, btn_inc held 3 ticks → mode=01, min=3, sec frozen. mode_rise → 10; btn_inc from sec=59 → sec=0, min stays 3.
- alarm_en=1, alarm_min=1 (set in SET_ALM), time 00:58 in RUN → ring=1 on the edge producing 01:00, high for RING_LEN=30 ticks, then 0.
- Ringing, btn_mode pulsed → ring=0 next edge, mode stays RUN. Ringing, alarm_en→0 → ring=0 next edge.
- With `CLOCK_SNOOZE_EN`: ringing, btn_inc pulse → ring=0, then re-asserts exactly SNOOZE_LEN=60 ticks later. Without the macro, the same stimulus gives ring=0 and no re-ring.
- rst pulse mid-ring at time 01:05 → ring=0, sec=0, min=0, alarm_min=0, mode=00 immediately (before the next edge), and no re-trigger at 00:00.
